// File: rtl/imem_boot_loader_pkg.sv
// Shared types and constants for the instruction-memory boot loader.
package imem_boot_loader_pkg;

  // Loader sequencing: wait for start, read the word count, stream words, then finish.
  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LEN  = 3'd1,
    DATA = 3'd2,
    DONE = 3'd3,
    ERR  = 3'd4
  } loader_state_e;

  // Bytes packed into one instruction word, least significant byte first.
  localparam int BYTES_PER_WORD = 4;

endpackage

// File: rtl/imem_boot_loader_if.sv
// Byte-stream input and instruction RAM write port of the boot loader.
//
// Handshake: the source drives rx_data/rx_valid, the loader drives rx_ready.
// A byte transfers on every rising clk edge where rx_valid & rx_ready are both 1.
// The source must hold rx_data stable while rx_valid=1 and no transfer has
// occurred; rx_ready does not depend on rx_valid. The RAM write port has no
// back-pressure: is_write=1 for one clk commits im_inst at byte address im_addr.
interface imem_boot_loader_if #(
  parameter int w = 32
);
  logic [7:0]   rx_data;
  logic         rx_valid;
  logic         rx_ready;
  logic         is_write;
  logic [w-1:0] im_addr;
  logic [w-1:0] im_inst;

  // Byte source / RAM observer side.
  modport master (
    output rx_data, rx_valid,
    input  rx_ready, is_write, im_addr, im_inst
  );

  // Loader side.
  modport slave (
    input  rx_data, rx_valid,
    output rx_ready, is_write, im_addr, im_inst
  );
endinterface

// File: rtl/imem_boot_loader.sv
// Boot loader: receives a little-endian word count followed by that many
// little-endian 32-bit words and writes them to instruction RAM from address 0.
// Holds the core until the image has been written completely.
module imem_boot_loader
  import imem_boot_loader_pkg::*;
#(
  parameter int w       = 32,
  parameter int h       = 8,
  parameter int TIMEOUT = 100000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  imem_boot_loader_if.slave   bus,
  output logic                core_hold,
  output logic                load_done,
  output logic                load_err,
  output logic [h:0]          words_loaded,
  output loader_state_e       dbg_state
);

  // Idle counter only needs to reach TIMEOUT-1; one more idle cycle is the timeout.
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] IDLE_LAST = TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam logic [w:0]    MAX_WORDS = (w + 1)'(1) << h;
  localparam logic [1:0]    LAST_BYTE = 2'(BYTES_PER_WORD - 1);

  loader_state_e state_q, state_d;

  logic [1:0]    byte_cnt_q, byte_cnt_d;
  logic [w-1:0]  pack_q, pack_d;
  logic [h-1:0]  word_idx_q, word_idx_d;
  logic [h:0]    n_words_q, n_words_d;
  logic [h:0]    words_q, words_d;
  logic [TW-1:0] idle_q, idle_d;
  logic          rx_ready_q, rx_ready_d;
  logic          is_write_q, is_write_d;
  logic [w-1:0]  addr_q, addr_d;
  logic [w-1:0]  inst_q, inst_d;
  logic          hold_q, hold_d;
  logic          done_q, done_d;
  logic          err_q, err_d;

  logic          accept;
  logic          byte_last;
  logic [w-1:0]  pack_next;
  logic [h:0]    words_inc;

  assign accept    = bus.rx_valid & rx_ready_q;
  assign byte_last = (byte_cnt_q == LAST_BYTE);
  // New bytes enter at the top so the first byte ends up in bits [7:0].
  assign pack_next = {bus.rx_data, pack_q[w-1:8]};
  assign words_inc = words_q + 1'b1;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next state, datapath updates and registered-output next values.
  always_comb begin
    state_d    = state_q;
    byte_cnt_d = byte_cnt_q;
    pack_d     = pack_q;
    word_idx_d = word_idx_q;
    n_words_d  = n_words_q;
    words_d    = words_q;
    idle_d     = idle_q;
    is_write_d = 1'b0;
    addr_d     = addr_q;
    inst_d     = inst_q;

    if (accept) begin
      pack_d     = pack_next;
      byte_cnt_d = byte_cnt_q + 2'd1;
    end

    case (state_q)
      IDLE, DONE, ERR: begin
        if (start) begin
          state_d    = LEN;
          byte_cnt_d = 2'd0;
          word_idx_d = '0;
          n_words_d  = '0;
          words_d    = '0;
          idle_d     = '0;
        end
      end
      LEN: begin
        if (accept && byte_last) begin
          if (pack_next == '0) begin
            state_d = DONE;
          end else if ({1'b0, pack_next} > MAX_WORDS) begin
            state_d = ERR;
          end else begin
            state_d   = DATA;
            n_words_d = pack_next[h:0];
          end
        end
      end
      DATA: begin
        if (accept && byte_last) begin
          is_write_d = 1'b1;
          addr_d     = w'({word_idx_q, 2'b00});
          inst_d     = pack_next;
          words_d    = words_inc;
          if (words_inc == n_words_q) state_d = DONE;
          else                        word_idx_d = word_idx_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // Inter-byte watchdog while a load is in progress.
    if (state_q == LEN || state_q == DATA) begin
      if (accept) begin
        idle_d = '0;
      end else if (TIMEOUT != 0) begin
        if (idle_q == IDLE_LAST) state_d = ERR;
        else                     idle_d  = idle_q + 1'b1;
      end
    end

    // Status levels follow the state one clk later, so done rises after the last write strobe.
    rx_ready_d = (state_d == LEN) || (state_d == DATA);
    done_d     = (state_q == DONE) && (state_d == DONE);
    err_d      = (state_q == ERR) && (state_d == ERR);
    hold_d     = !done_d;
  end

  // Datapath and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      byte_cnt_q <= '0;
      pack_q     <= '0;
      word_idx_q <= '0;
      n_words_q  <= '0;
      words_q    <= '0;
      idle_q     <= '0;
      rx_ready_q <= 1'b0;
      is_write_q <= 1'b0;
      addr_q     <= '0;
      inst_q     <= '0;
      hold_q     <= 1'b1;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      byte_cnt_q <= byte_cnt_d;
      pack_q     <= pack_d;
      word_idx_q <= word_idx_d;
      n_words_q  <= n_words_d;
      words_q    <= words_d;
      idle_q     <= idle_d;
      rx_ready_q <= rx_ready_d;
      is_write_q <= is_write_d;
      addr_q     <= addr_d;
      inst_q     <= inst_d;
      hold_q     <= hold_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  assign bus.rx_ready  = rx_ready_q;
  assign bus.is_write  = is_write_q;
  assign bus.im_addr   = addr_q;
  assign bus.im_inst   = inst_q;
  assign core_hold     = hold_q;
  assign load_done     = done_q;
  assign load_err      = err_q;
  assign words_loaded  = words_q;
  assign dbg_state     = state_q;

endmodule

// File: tb/tb_imem_boot_loader.sv
// Bench for imem_boot_loader: table of loads, randomized loads, and
// hand-written timeout / reset / reload sequences.
module tb_imem_boot_loader;
  import imem_boot_loader_pkg::*;

  localparam int W    = 32;
  localparam int H    = 4;
  localparam int TO   = 16;
  localparam int MAXW = 1 << H;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  logic start;
  logic core_hold;
  logic load_done;
  logic load_err;
  logic [H:0] words_loaded;
  loader_state_e dbg_state;

  always #5 clk = ~clk;

  imem_boot_loader_if #(.w(W)) bus ();

  imem_boot_loader #(.w(W), .h(H), .TIMEOUT(TO)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .bus          (bus),
    .core_hold    (core_hold),
    .load_done    (load_done),
    .load_err     (load_err),
    .words_loaded (words_loaded),
    .dbg_state    (dbg_state)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail   = 0;
  logic [63:0] exp_q[$];            // {byte address, instruction word}
  logic [7:0]  data_buf [0:4*MAXW-1];
  bit watch_hold   = 1'b0;
  bit hold_dropped = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
    end
  endtask

  // Every write strobe must match the next expected RAM write.
  always @(negedge clk) begin
    if (bus.is_write === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_write: got addr 0x%0h inst 0x%0h required no write",
                 bus.im_addr, bus.im_inst);
      end else begin
        check("ram_write", {bus.im_addr, bus.im_inst}, exp_q.pop_front());
      end
    end
    if (watch_hold && core_hold !== 1'b1) hold_dropped = 1'b1;
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    bit ok;
    ok = 1'b0;
    bus.rx_valid = 1'b1;
    bus.rx_data  = b;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (bus.rx_ready === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    @(posedge clk);
    #1;
    bus.rx_valid = 1'b0;
    if (!ok) begin
      n_checks++;
      n_fail++;
      $display("FAIL send_byte: got rx_ready=0 for 50 clks required 1");
    end
  endtask

  task automatic send_gap(input logic [7:0] b);
    repeat ($urandom_range(0, 2)) tick();
    send_byte(b);
  endtask

  task automatic send_word32(input logic [31:0] v);
    for (int k = 0; k < 4; k++) send_gap(8'((v >> (8 * k)) & 32'hFF));
  endtask

  task automatic wait_end(input string name);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (load_done === 1'b1 || load_err === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    check({name, "/finished"}, seen, 1'b1);
  endtask

  // Reference model: word k of the image is bytes 4k..4k+3, least significant first,
  // written at byte address 4k.
  function automatic logic [31:0] model_word(input int k);
    logic [31:0] v;
    v = 0;
    for (int j = 0; j < 4; j++) v = v + (32'(data_buf[4 * k + j]) << (8 * j));
    return v;
  endfunction

  task automatic do_load(input string name, input logic [31:0] count,
                         input bit exp_done, input bit exp_err, input int exp_words);
    for (int k = 0; k < exp_words; k++) exp_q.push_back({32'(4 * k), model_word(k)});
    pulse_start();
    send_word32(count);
    for (int i = 0; i < 4 * exp_words; i++) send_gap(data_buf[i]);
    wait_end(name);
    check({name, "/load_done"}, load_done, exp_done);
    check({name, "/load_err"}, load_err, exp_err);
    check({name, "/core_hold"}, core_hold, !exp_done);
    check({name, "/words_loaded"}, words_loaded, exp_words);
    check({name, "/rx_ready"}, bus.rx_ready, 1'b0);
    check({name, "/pending_writes"}, exp_q.size(), 0);
    if (exp_words > 0)
      check({name, "/held_write_port"}, {bus.im_addr, bus.im_inst},
            {32'(4 * (exp_words - 1)), model_word(exp_words - 1)});
  endtask

  task automatic fill_random();
    for (int i = 0; i < 4 * MAXW; i++) data_buf[i] = 8'($urandom_range(0, 255));
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [31:0] count;
    bit          seq_data;
    bit          exp_done;
    bit          exp_err;
    int          exp_words;
  } vec_t;

  vec_t vecs [7];

  initial begin
    #500000;
    $display("FAIL watchdog: got no end of test required end within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{32'd3,          1'b1, 1'b1, 1'b0, 3};
    vecs[1] = '{32'd0,          1'b0, 1'b1, 1'b0, 0};
    vecs[2] = '{32'd17,         1'b0, 1'b0, 1'b1, 0};
    vecs[3] = '{32'd16,         1'b0, 1'b1, 1'b0, 16};
    vecs[4] = '{32'd1,          1'b0, 1'b1, 1'b0, 1};
    vecs[5] = '{32'h8000_0000,  1'b0, 1'b0, 1'b1, 0};
    vecs[6] = '{32'h0001_0002,  1'b0, 1'b0, 1'b1, 0};

    rst          = 1'b1;
    start        = 1'b0;
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;
    repeat (3) tick();
    rst = 1'b0;
    @(negedge clk);
    check("reset/rx_ready", bus.rx_ready, 1'b0);
    check("reset/is_write", bus.is_write, 1'b0);
    check("reset/im_addr", bus.im_addr, 0);
    check("reset/im_inst", bus.im_inst, 0);
    check("reset/core_hold", core_hold, 1'b1);
    check("reset/load_done", load_done, 1'b0);
    check("reset/load_err", load_err, 1'b0);
    check("reset/words_loaded", words_loaded, 0);
    tick();

    // Table of loads.
    for (int v = 0; v < 7; v++) begin
      if (vecs[v].seq_data) for (int i = 0; i < 4 * MAXW; i++) data_buf[i] = 8'(i);
      else fill_random();
      do_load($sformatf("vec%0d", v), vecs[v].count, vecs[v].exp_done,
              vecs[v].exp_err, vecs[v].exp_words);
      repeat ($urandom_range(0, 3)) tick();
    end

    // Randomized loads checked against the count rule.
    for (int r = 0; r < 6; r++) begin
      int n;
      bit ok_len;
      n = $urandom_range(0, MAXW + 3);
      ok_len = (n <= MAXW);
      fill_random();
      do_load($sformatf("rand%0d", r), 32'(n), ok_len, !ok_len, ok_len ? n : 0);
    end

    // Timeout after two data bytes, then a clean restart.
    begin
      int cyc;
      pulse_start();
      send_word32(32'd2);
      send_byte(8'hA0);
      send_byte(8'hA1);
      cyc = 0;
      for (int i = 0; i < 40; i++) begin
        @(negedge clk);
        cyc++;
        if (load_err === 1'b1) break;
      end
      check("timeout/latency_in_range", (cyc >= TO && cyc <= TO + 2), 1'b1);
      check("timeout/load_err", load_err, 1'b1);
      check("timeout/core_hold", core_hold, 1'b1);
      check("timeout/load_done", load_done, 1'b0);
      tick();
      fill_random();
      do_load("after_timeout", 32'd1, 1'b1, 1'b0, 1);
    end

    // Reset in the middle of a word aborts the load.
    pulse_start();
    send_word32(32'd1);
    send_byte(8'h11);
    send_byte(8'h22);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("midreset/core_hold", core_hold, 1'b1);
    check("midreset/load_done", load_done, 1'b0);
    check("midreset/words_loaded", words_loaded, 0);
    check("midreset/rx_ready", bus.rx_ready, 1'b0);
    tick();
    fill_random();
    do_load("after_reset", 32'd1, 1'b1, 1'b0, 1);

    // Reload with a start pulse during DATA that must be ignored.
    fill_random();
    for (int k = 0; k < 2; k++) exp_q.push_back({32'(4 * k), model_word(k)});
    pulse_start();
    hold_dropped = 1'b0;
    watch_hold   = 1'b1;
    send_word32(32'd2);
    send_byte(data_buf[0]);
    send_byte(data_buf[1]);
    pulse_start();
    for (int i = 2; i < 8; i++) send_gap(data_buf[i]);
    watch_hold = 1'b0;
    wait_end("reload");
    check("reload/load_done", load_done, 1'b1);
    check("reload/words_loaded", words_loaded, 2);
    check("reload/hold_kept", hold_dropped, 1'b0);
    check("reload/pending_writes", exp_q.size(), 0);
    check("reload/core_hold_released", core_hold, 1'b0);

    repeat (3) tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
